// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and receive FSM state encoding.
package uart_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RECV  = 2'd2;
  localparam logic [1:0] ST_BREAK = 2'd3;

endpackage

// File: rtl/uart_rx_sampler_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle level.
module rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: start detect, mid-bit strobe generation, deserialisation
// and a valid/read character handshake with sticky error flags.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned WD_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       seq_complete,
  input  logic       char_read,
  output logic       sr_clock,
  output logic       bic_en,
  output logic [7:0] char_data,
  output logic       char_valid,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       sync_err
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] WD_LAST   = BW'(WD_CYCLES - 1);
  localparam logic [3:0]    SCNT_LAST = 4'(FRAME_BITS);

  logic                 rx_s;
  logic                 rx_s_d;
  logic [1:0]           state_q, state_d;
  logic [BW-1:0]        cnt_q, cnt_d;
  logic [3:0]           scnt_q, scnt_d;
  logic [DATA_BITS:0]   shreg_q, shreg_d;
  logic                 sr_clock_d, bic_en_d, char_valid_d;
  logic                 framing_d, overrun_d, sync_d;
  logic [7:0]           char_data_d;

  rx_sync u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      scnt_q      <= '0;
      shreg_q     <= '0;
      rx_s_d      <= 1'b1;
      sr_clock    <= 1'b0;
      bic_en      <= 1'b0;
      char_data   <= 8'h00;
      char_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scnt_q      <= scnt_d;
      shreg_q     <= shreg_d;
      rx_s_d      <= rx_s;
      sr_clock    <= sr_clock_d;
      bic_en      <= bic_en_d;
      char_data   <= char_data_d;
      char_valid  <= char_valid_d;
      framing_err <= framing_d;
      overrun_err <= overrun_d;
      sync_err    <= sync_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + BW'(1);
    scnt_d       = scnt_q;
    shreg_d      = shreg_q;
    sr_clock_d   = 1'b0;
    bic_en_d     = bic_en;
    char_data_d  = char_data;
    char_valid_d = char_valid;
    framing_d    = framing_err;
    overrun_d    = overrun_err;
    sync_d       = sync_err;

    if (char_read) begin
      char_valid_d = 1'b0;
      framing_d    = 1'b0;
      overrun_d    = 1'b0;
      sync_d       = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        scnt_d   = '0;
        bic_en_d = 1'b0;
        if (rx_s_d && !rx_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            sr_clock_d = 1'b1;
            bic_en_d   = 1'b1;
            scnt_d     = 4'd1;
            state_d    = ST_RECV;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RECV: begin
        if (scnt_q != SCNT_LAST) begin
          if (seq_complete) begin
            // Counter claims a full frame before we produced it.
            sync_d   = 1'b1;
            bic_en_d = 1'b0;
            cnt_d    = '0;
            state_d  = ST_BREAK;
          end else if (cnt_q == BIT_LAST) begin
            cnt_d      = '0;
            sr_clock_d = 1'b1;
            scnt_d     = scnt_q + 4'd1;
            shreg_d    = {rx_s, shreg_q[DATA_BITS:1]};
          end
        end else if (seq_complete) begin
          // New character wins over a same-cycle read; overrun only if unread.
          if (char_valid && !char_read) begin
            overrun_d = 1'b1;
          end
          char_data_d  = shreg_q[DATA_BITS-1:0];
          char_valid_d = 1'b1;
          framing_d    = framing_d | ~shreg_q[DATA_BITS];
          bic_en_d     = 1'b0;
          cnt_d        = '0;
          state_d      = shreg_q[DATA_BITS] ? ST_IDLE : ST_BREAK;
        end else if (cnt_q == WD_LAST) begin
          sync_d   = 1'b1;
          bic_en_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_BREAK;
        end
      end

      ST_BREAK: begin
        bic_en_d = 1'b0;
        if (!rx_s) begin
          cnt_d = '0;
        end else if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Randomised frame-level bench for uart_rx_sampler with a behavioural bit counter.
module tb_uart_rx_sampler;

  localparam int CLKS      = 16;
  localparam int WD        = 4;
  // Two synchroniser flops plus one cycle to register the edge, then half a bit.
  localparam int FIRST_LAT = 3 + CLKS / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       seq_complete;
  logic       char_read;
  logic       sr_clock;
  logic       bic_en;
  logic [7:0] char_data;
  logic       char_valid;
  logic       framing_err;
  logic       overrun_err;
  logic       sync_err;

  uart_rx_sampler #(.CLKS_PER_BIT(CLKS), .WD_CYCLES(WD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .seq_complete (seq_complete),
    .char_read    (char_read),
    .sr_clock     (sr_clock),
    .bic_en       (bic_en),
    .char_data    (char_data),
    .char_valid   (char_valid),
    .framing_err  (framing_err),
    .overrun_err  (overrun_err),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  // Bit-in-character counter: counts strobes while framed; char_read clears it.
  logic [3:0] bc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  bc <= 4'd0;
    else if (!bic_en || char_read) bc <= 4'd0;
    else if (sr_clock && bc != 4'd10) bc <= bc + 4'd1;
  end
  assign seq_complete = (bc == 4'd10);

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor sampled just after each active edge.
  int cyc = 0;
  int pulses[$];
  int b2b = 0;
  int se_rise = -1;
  bit prev_sr = 1'b0;
  bit prev_se = 1'b0;
  bit bic_seen = 1'b0;
  int start_cyc = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (sr_clock) begin
      pulses.push_back(cyc);
      if (prev_sr) b2b++;
    end
    prev_sr = sr_clock;
    if (bic_en) bic_seen = 1'b1;
    if (sync_err && !prev_se) se_rise = cyc;
    prev_se = sync_err;
  end

  // Reference model of the character interface.
  logic [7:0] m_data;
  logic m_valid, m_fe, m_oe, m_se;

  task automatic model_reset();
    m_data = 8'h00; m_valid = 0; m_fe = 0; m_oe = 0; m_se = 0;
  endtask

  task automatic model_read();
    m_valid = 0; m_fe = 0; m_oe = 0; m_se = 0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop, input bit read_same);
    if (read_same) model_read();
    else if (m_valid) m_oe = 1;
    m_data  = d;
    m_valid = 1;
    m_fe    = m_fe | ~stop;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_data"},  32'(char_data),   32'(m_data));
    chk({tag, "_valid"}, 32'(char_valid),  32'(m_valid));
    chk({tag, "_ferr"},  32'(framing_err), 32'(m_fe));
    chk({tag, "_oerr"},  32'(overrun_err), 32'(m_oe));
    chk({tag, "_serr"},  32'(sync_err),    32'(m_se));
    chk({tag, "_bic"},   32'(bic_en),      32'(0));
  endtask

  task automatic check_frame(input string tag);
    int bad;
    chk({tag, "_npulse"}, 32'(pulses.size()), 32'(10));
    if (pulses.size() > 0) begin
      chk({tag, "_first"}, 32'(pulses[0] - start_cyc), 32'(FIRST_LAT));
      bad = 0;
      for (int i = 1; i < pulses.size(); i++)
        if (pulses[i] - pulses[i-1] != CLKS) bad++;
      chk({tag, "_spacing"}, 32'(bad), 32'(0));
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    pulses.delete();
    se_rise = -1;
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CLKS) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic pulse_read();
    char_read = 1'b1;
    @(negedge clk);
    char_read = 1'b0;
    model_read();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic       s;
    int         n;
    rst_n = 1'b0; rx = 1'b1; char_read = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_sr", 32'(sr_clock), 32'(0));
    check_outputs("rst");
    rst_n = 1'b1;
    idle(8);

    // Good frame 0x5A.
    send_frame(8'h5A, 1'b1); idle(6);
    model_frame(8'h5A, 1'b1, 0);
    check_frame("f5a"); check_outputs("f5a");
    pulse_read();

    // False start: short low pulse.
    pulses.delete(); bic_seen = 0;
    rx = 1'b0; repeat (5) @(negedge clk);
    idle(30);
    chk("false_npulse", 32'(pulses.size()), 32'(0));
    chk("false_bic", 32'(bic_seen), 32'(0));

    // Bad stop bit, then the line must be high a full bit before a new start.
    send_frame(8'hA5, 1'b0);
    model_frame(8'hA5, 1'b0, 0);
    check_frame("fa5");
    pulses.delete(); bic_seen = 0;
    idle(8);
    rx = 1'b0; repeat (20) @(negedge clk);
    idle(8);
    rx = 1'b0; repeat (20) @(negedge clk);
    idle(40);
    chk("brk_npulse", 32'(pulses.size()), 32'(0));
    chk("brk_bic", 32'(bic_seen), 32'(0));
    check_outputs("fa5");
    pulse_read();
    check_outputs("fa5_rd");

    // Overrun: two frames without a read.
    send_frame(8'h11, 1'b1); idle(4); model_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1); idle(6); model_frame(8'h22, 1'b1, 0);
    check_frame("f22"); check_outputs("ovr");
    pulse_read(); check_outputs("ovr_rd");

    // Read arriving in the frame-close cycle.
    send_frame(8'h77, 1'b1); idle(6); model_frame(8'h77, 1'b1, 0);
    fork
      send_frame(8'h88, 1'b1);
      begin
        n = 0;
        while (!seq_complete && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("coinc_timeout", 32'(1), 32'(0));
        else begin
          char_read = 1'b1; @(negedge clk); char_read = 1'b0;
        end
      end
    join
    idle(6); model_frame(8'h88, 1'b1, 1);
    check_frame("f88"); check_outputs("coinc");
    pulse_read();

    // Read mid-frame clears the bit counter, so seq_complete never arrives.
    fork
      send_frame(8'h6B, 1'b1);
      begin
        repeat (80) @(negedge clk);
        char_read = 1'b1; @(negedge clk); char_read = 1'b0;
      end
    join
    idle(6);
    model_read(); m_se = 1;
    check_frame("wd");
    if (pulses.size() == 10) chk("wd_lat", 32'(se_rise - pulses[9]), 32'(WD));
    check_outputs("wd");
    idle(24);
    pulse_read();
    d = 8'($urandom);
    send_frame(d, 1'b1); idle(6); model_frame(d, 1'b1, 0);
    check_frame("recov"); check_outputs("recov");
    pulse_read();

    // Reset at the fifth strobe; remaining line bits are high so nothing retriggers.
    fork
      send_frame(8'hFA, 1'b1);
      begin
        n = 0;
        while (pulses.size() < 5 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("rst_timeout", 32'(1), 32'(0));
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mrst_sr", 32'(sr_clock), 32'(0));
        check_outputs("mrst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
      end
    join
    idle(24);
    check_outputs("post_rst");
    send_frame(8'h3C, 1'b1); idle(6); model_frame(8'h3C, 1'b1, 0);
    check_frame("f3c"); check_outputs("f3c");

    // Random frames with random stop bits and reads.
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, s);
      idle(24 + int'($urandom_range(0, 5)));
      model_frame(d, s, 0);
      check_frame("rnd"); check_outputs("rnd");
      if ($urandom_range(0, 1) == 1) pulse_read();
    end

    chk("sr_b2b", 32'(b2b), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
